// File: rtl/clk_pkg.sv
// clk_pkg: edit-mode encoding, field limits and wrap helper shared by the clock blocks
package clk_pkg;
  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_SEC    = 2'd1;
  localparam logic [1:0] MODE_MIN    = 2'd2;
  localparam logic [1:0] MODE_HOUR   = 2'd3;
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_e;
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max, input logic inc);
    return inc ? (v == max ? 6'd0 : v + 6'd1) : (v == 6'd0 ? max : v - 6'd1);
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: 5-bit rising-edge detector against the previous clk's registered level
module btn_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_i,
  output logic [4:0] rise_o
);
  logic [4:0] prev_q;
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 5'd0;
    else prev_q <= btn_i;
  end
  assign rise_o = btn_i & ~prev_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hh:mm:ss edit FSM with timeout; TIME_SET_AUTOREPEAT_EN adds up/down auto-repeat
module time_set_ctrl
  import clk_pkg::*;
#(
  parameter int TIMEOUT_S  = 30,
  parameter int RPT_DLY_MS = 500,
  parameter int RPT_PER_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       secclk_p,
  input  logic       msecclk_p,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       middle,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic [1:0] edit_mode,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load,
  output logic       blink
);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  state_e state_q;
  logic [1:0] mode_q, mode_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d, sec_q, sec_d, hour_w;
  logic [TW-1:0] tmo_q;
  logic load_q, blink_q;
  logic [4:0] rise;
  logic lr_ok, ud_ev, rpt_step, step_ev, step_inc, acc;
  btn_edge u_edge (.clk(clk), .rst(rst), .btn_i({middle, left, right, up, down}), .rise_o(rise));
  // middle outranks left/right, which outrank up/down; opposing pairs cancel
  always_comb begin
    lr_ok = ~rise[4] & (rise[3] ^ rise[2]);
    ud_ev = ~rise[4] & ~(rise[3] | rise[2]) & (rise[1] ^ rise[0]);
    step_ev = ud_ev | rpt_step;
    step_inc = ud_ev ? rise[1] : up;
    acc = lr_ok | step_ev;
    mode_d = rise[3] ? (mode_q == MODE_HOUR ? MODE_SEC : mode_q + 2'd1)
                     : (mode_q == MODE_SEC ? MODE_HOUR : mode_q - 2'd1);
    hour_w = wrap_step({1'b0, hour_q}, HOUR_MAX, step_inc);
    hour_d = (step_ev && mode_q == MODE_HOUR) ? hour_w[4:0] : hour_q;
    min_d = (step_ev && mode_q == MODE_MIN) ? wrap_step(min_q, MIN_MAX, step_inc) : min_q;
    sec_d = (step_ev && mode_q == MODE_SEC) ? wrap_step(sec_q, SEC_MAX, step_inc) : sec_q;
  end
`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RW = $clog2((RPT_DLY_MS > RPT_PER_MS ? RPT_DLY_MS : RPT_PER_MS) + 1);
  logic [RW-1:0] rcnt_q;
  logic armed_q, hold;
  assign hold = (state_q == EDIT) & (up ^ down) & ~left & ~right & ~middle;
  assign rpt_step = hold & msecclk_p & armed_q & ~ud_ev & (rcnt_q == RW'(RPT_PER_MS - 1));
  // the initial delay only arms the repeater; steps come every period after that
  always_ff @(posedge clk) begin
    if (rst || !hold || ud_ev) begin
      rcnt_q <= '0;
      armed_q <= 1'b0;
    end else if (msecclk_p) begin
      if (!armed_q && rcnt_q == RW'(RPT_DLY_MS - 1)) begin
        armed_q <= 1'b1;
        rcnt_q <= '0;
      end else if (armed_q && rcnt_q == RW'(RPT_PER_MS - 1)) rcnt_q <= '0;
      else rcnt_q <= rcnt_q + 1'b1;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = msecclk_p | (RPT_DLY_MS == RPT_PER_MS);
  assign rpt_step = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= MODE_NORMAL;
      hour_q <= '0;
      min_q <= '0;
      sec_q <= '0;
      tmo_q <= '0;
      load_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE: if (rise[4]) begin
          state_q <= EDIT;
          mode_q <= MODE_HOUR;
          hour_q <= cur_hour;
          min_q <= cur_minute;
          sec_q <= cur_second;
          tmo_q <= '0;
          blink_q <= 1'b1;
        end
        EDIT: begin
          if (secclk_p) blink_q <= ~blink_q;
          if (rise[4]) begin
            state_q <= COMMIT;
            mode_q <= MODE_NORMAL;
            load_q <= 1'b1;
            blink_q <= 1'b0;
          end else begin
            if (lr_ok) mode_q <= mode_d;
            hour_q <= hour_d;
            min_q <= min_d;
            sec_q <= sec_d;
            if (acc) tmo_q <= '0;
            else if (secclk_p) begin
              if (tmo_q == TW'(TIMEOUT_S - 1)) begin
                state_q <= IDLE;
                mode_q <= MODE_NORMAL;
                blink_q <= 1'b0;
                tmo_q <= '0;
              end else tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign edit_mode = mode_q;
  assign set_hour = hour_q;
  assign set_minute = min_q;
  assign set_second = sec_q;
  assign load = load_q;
  assign blink = blink_q;
endmodule
